// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared state encodings and defaults for mult_arbiter
package mult_arb_pkg;

    localparam int NREQ_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_ACK  = 3'd3,
        S_RESP = 3'd4
    } arb_state_t;

    typedef enum logic [2:0] {
        M_IDLE  = 3'd0,
        M_INIT  = 3'd1,
        M_CHECK = 3'd2,
        M_ADD   = 3'd3,
        M_SHIFT = 3'd4,
        M_DONE  = 3'd5
    } mul_state_t;

endpackage

// File: rtl/booths_multiplier.sv
// rtl/booths_multiplier.sv - sequential radix-2 Booth signed multiplier with load/done handshake
module booths_multiplier
    import mult_arb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           recieved,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] c,
    output logic           init,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    mul_state_t      mstate_q, mstate_d;
    // Accumulator carries one guard bit so subtracting the most negative
    // multiplicand cannot overflow.
    logic [N:0]      acc_q, acc_d;
    logic [N:0]      m_q, m_d;
    logic [N-1:0]    q_q, q_d;
    logic            qm1_q, qm1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            init_q, init_d;
    logic            done_q, done_d;
    logic [2*N-1:0]  c_q, c_d;
    logic [2*N+1:0]  shifted;

    assign shifted = {acc_q[N], acc_q, q_q, qm1_q} >> 1;

    always_comb begin
        mstate_d = mstate_q;
        acc_d    = acc_q;
        m_d      = m_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        init_d   = 1'b0;
        done_d   = done_q;
        c_d      = c_q;
        case (mstate_q)
            M_IDLE: begin
                if (load) mstate_d = M_INIT;
            end
            M_INIT: begin
                acc_d    = '0;
                m_d      = {b[N-1], b};
                q_d      = a;
                qm1_d    = 1'b0;
                cnt_d    = '0;
                init_d   = 1'b1;
                mstate_d = M_CHECK;
            end
            M_CHECK: begin
                if (q_q[0] != qm1_q) mstate_d = M_ADD;
                else                 mstate_d = M_SHIFT;
            end
            M_ADD: begin
                // Pair 10 starts a run of ones (subtract), 01 ends it (add).
                acc_d    = q_q[0] ? (acc_q - m_q) : (acc_q + m_q);
                mstate_d = M_SHIFT;
            end
            M_SHIFT: begin
                acc_d = shifted[2*N+1:N+1];
                q_d   = shifted[N:1];
                qm1_d = shifted[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    c_d      = shifted[2*N:1];
                    done_d   = 1'b1;
                    mstate_d = M_DONE;
                end else begin
                    mstate_d = M_CHECK;
                end
            end
            M_DONE: begin
                if (recieved) begin
                    done_d   = 1'b0;
                    mstate_d = M_IDLE;
                end
            end
            default: mstate_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstate_q <= M_IDLE;
            acc_q    <= '0;
            m_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            init_q   <= 1'b0;
            done_q   <= 1'b0;
            c_q      <= '0;
        end else begin
            mstate_q <= mstate_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            init_q   <= init_d;
            done_q   <= done_d;
            c_q      <= c_d;
        end
    end

    assign c    = c_q;
    assign init = init_q;
    assign done = done_q;

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting after the last grant
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    localparam int LW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic [LW-1:0]   gnt_idx,
    output logic            any
);

    logic [LW-1:0] idx;

    // Walk from farthest to nearest so the nearest set bit after last wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = LW'((int'(last) + k) % NREQ);
            if (req[idx]) begin
                gnt_idx = idx;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sequencer sharing one Booth multiplier among NREQ requesters
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [2*N-1:0]    rsp_c,
    output logic              busy
);

    localparam int LW = $clog2(NREQ);

    arb_state_t       state_q, state_d;
    logic [LW-1:0]    gnt_id_q, gnt_id_d;
    logic [LW-1:0]    last_gnt_q, last_gnt_d;
    logic [N-1:0]     mul_a_q, mul_a_d;
    logic [N-1:0]     mul_b_q, mul_b_d;
    logic             mul_load_q, mul_load_d;
    logic             mul_recieved_q, mul_recieved_d;
    logic [NREQ-1:0]  req_ack_q, req_ack_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [2*N-1:0]   rsp_c_q, rsp_c_d;
    logic             busy_q, busy_d;

    logic [LW-1:0]    pick_idx;
    logic             pick_any;
    logic [2*N-1:0]   mul_c;
    logic             mul_init;
    logic             mul_done;
    logic             mul_rst_n;

    assign mul_rst_n = ~rst;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req_valid),
        .last    (last_gnt_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    booths_multiplier #(.N(N)) u_mul (
        .clk      (clk),
        .rst_n    (mul_rst_n),
        .load     (mul_load_q),
        .recieved (mul_recieved_q),
        .a        (mul_a_q),
        .b        (mul_b_q),
        .c        (mul_c),
        .init     (mul_init),
        .done     (mul_done)
    );

    always_comb begin
        state_d        = state_q;
        gnt_id_d       = gnt_id_q;
        last_gnt_d     = last_gnt_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        mul_load_d     = mul_load_q;
        mul_recieved_d = mul_recieved_q;
        req_ack_d      = '0;
        rsp_valid_d    = rsp_valid_q;
        rsp_c_d        = rsp_c_q;
        case (state_q)
            S_IDLE: begin
                // A done left over from before reset must be drained before
                // any new grant, otherwise it would be taken as our result.
                mul_recieved_d = mul_done;
                if (!mul_done && pick_any) begin
                    gnt_id_d   = pick_idx;
                    mul_a_d    = req_a[int'(pick_idx)*N +: N];
                    mul_b_d    = req_b[int'(pick_idx)*N +: N];
                    mul_load_d = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (mul_init) begin
                    mul_load_d          = 1'b0;
                    req_ack_d[gnt_id_q] = 1'b1;
                    state_d             = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_done) begin
                    rsp_c_d        = mul_c;
                    mul_recieved_d = 1'b1;
                    state_d        = S_ACK;
                end
            end
            S_ACK: begin
                if (!mul_done) begin
                    mul_recieved_d        = 1'b0;
                    rsp_valid_d[gnt_id_q] = 1'b1;
                    state_d               = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[gnt_id_q]) begin
                    rsp_valid_d = '0;
                    last_gnt_d  = gnt_id_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            gnt_id_q       <= '0;
            last_gnt_q     <= LW'(NREQ - 1);
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            mul_load_q     <= 1'b0;
            mul_recieved_q <= 1'b0;
            req_ack_q      <= '0;
            rsp_valid_q    <= '0;
            rsp_c_q        <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_id_q       <= gnt_id_d;
            last_gnt_q     <= last_gnt_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            mul_load_q     <= mul_load_d;
            mul_recieved_q <= mul_recieved_d;
            req_ack_q      <= req_ack_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_c_q        <= rsp_c_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - scoreboard bench for mult_arbiter
module tb_mult_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] prod;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [2*N-1:0]    rsp_c;
    logic              busy;

    int   checks;
    int   errors;
    exp_t sb[$];
    int   ack_cnt[NREQ];
    int   reload[NREQ];

    mult_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_proto
        assert property (@(posedge clk) disable iff (rst) $fell(req_valid[gi]) |-> req_ack[gi])
            else $error("request %0d dropped before ack", gi);
    end

    function automatic logic [63:0] mulx(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    task automatic push_exp(input int i);
        exp_t e;
        e.id   = 2'(i);
        e.prod = mulx(req_a[i*N +: N], req_b[i*N +: N]);
        sb.push_back(e);
    endtask

    task automatic drive_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_valid[i]    = 1'b1;
        push_exp(i);
    endtask

    // Requesters drop valid once acked, or re-request with the same operands
    // while they still have reloads left.
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (req_ack[i]) begin
                ack_cnt[i]++;
                if (reload[i] > 0) begin
                    reload[i]--;
                    push_exp(i);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    task automatic serve_one(input int stall, output int id, output logic [63:0] c,
                             output logic [3:0] vec, output bit ok);
        ok  = 1'b0;
        id  = -1;
        c   = '0;
        vec = '0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        vec = rsp_valid;
        c   = rsp_c;
        for (int i = NREQ - 1; i >= 0; i--) if (vec[i]) id = i;
        repeat (stall) @(negedge clk);
        rsp_ready = vec;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL reset_req_ack: got %b want 0000", req_ack); end
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        checks++; if (rsp_c !== 64'h0) begin errors++; $display("FAIL reset_rsp_c: got %h want 0", rsp_c); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int id; logic [63:0] c; logic [3:0] vec; bit ok; exp_t e; int acks0;
        acks0 = ack_cnt[0];
        drive_req(0, 32'd7, -32'sd3);
        serve_one(2, id, c, vec, ok);
        checks++;
        if (!ok || sb.size() == 0) begin errors++; $display("FAIL single_timeout: ok=%0d sb=%0d", ok, sb.size()); end
        else begin
            e = sb.pop_front();
            checks++; if (vec !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b want 0001", vec); end
            checks++; if (c !== e.prod) begin errors++; $display("FAIL single_rsp_c: got %h want %h", c, e.prod); end
            checks++; if (c !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL single_const: got %h want FFFFFFFFFFFFFFEB", c); end
        end
        repeat (2) @(negedge clk);
        checks++; if (ack_cnt[0] - acks0 != 1) begin errors++; $display("FAIL single_ack_count: got %0d want 1", ack_cnt[0] - acks0); end
        checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0) begin errors++; $display("FAIL single_idle: busy=%b rsp_valid=%b want 0/0000", busy, rsp_valid); end
    endtask

    task automatic test_all_four();
        int id; logic [63:0] c; logic [3:0] vec; bit ok; exp_t e;
        reset_dut();
        for (int i = 0; i < NREQ; i++) drive_req(i, 32'(i + 1), 32'd10);
        for (int k = 0; k < NREQ; k++) begin
            serve_one(k, id, c, vec, ok);
            checks++;
            if (!ok || sb.size() == 0) begin errors++; $display("FAIL all4_timeout_%0d: ok=%0d", k, ok); end
            else begin
                e = sb.pop_front();
                checks++; if (id != int'(e.id)) begin errors++; $display("FAIL all4_order_%0d: got %0d want %0d", k, id, e.id); end
                checks++; if (c !== e.prod) begin errors++; $display("FAIL all4_prod_%0d: got %0d want %0d", k, c, e.prod); end
                checks++; if ($countones(vec) != 1) begin errors++; $display("FAIL all4_onehot_%0d: got %b want one-hot", k, vec); end
            end
        end
    endtask

    task automatic test_backpressure();
        int id; logic [63:0] c; logic [3:0] vec; bit ok; exp_t e;
        logic [63:0] hold_c; bit stable; int acks0;
        drive_req(1, 32'd123456, -32'sd789);
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_timeout: rsp_valid never rose"); return; end
        hold_c = rsp_c;
        acks0  = ack_cnt[0];
        drive_req(0, 32'd3, 32'd3);
        stable = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0010 || rsp_c !== hold_c || dut.mul_load_q !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_stable: rsp_valid=%b rsp_c=%h want 0010/%h", rsp_valid, rsp_c, hold_c); end
        rsp_ready = 4'b0001;
        repeat (3) @(negedge clk);
        rsp_ready = 4'b0000;
        checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_foreign_ready: got %b want 0010", rsp_valid); end
        checks++; if (ack_cnt[0] != acks0) begin errors++; $display("FAIL bp_no_grant: got %0d acks want %0d", ack_cnt[0], acks0); end
        e = sb.pop_front();
        checks++; if (hold_c !== e.prod || e.id != 2'd1) begin errors++; $display("FAIL bp_prod: got %h want %h", hold_c, e.prod); end
        rsp_ready = 4'b0010;
        @(negedge clk);
        rsp_ready = 4'b0000;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL bp_release: got %b want 0000", rsp_valid); end
        serve_one(0, id, c, vec, ok);
        checks++;
        if (!ok || sb.size() == 0) begin errors++; $display("FAIL bp_next_timeout: ok=%0d", ok); end
        else begin
            e = sb.pop_front();
            checks++; if (id != int'(e.id) || c !== e.prod) begin errors++; $display("FAIL bp_next: got id %0d c %0d want id %0d c %0d", id, c, e.id, e.prod); end
        end
    endtask

    task automatic test_fairness();
        int id; logic [63:0] c; logic [3:0] vec; bit ok; exp_t e;
        reset_dut();
        reload[0] = 1;
        reload[2] = 1;
        drive_req(0, -32'sd5, -32'sd5);
        drive_req(2, -32'sd5, -32'sd5);
        for (int k = 0; k < 4; k++) begin
            serve_one(0, id, c, vec, ok);
            checks++;
            if (!ok || sb.size() == 0) begin errors++; $display("FAIL fair_timeout_%0d: ok=%0d", k, ok); end
            else begin
                e = sb.pop_front();
                checks++; if (id != int'(e.id)) begin errors++; $display("FAIL fair_order_%0d: got %0d want %0d", k, id, e.id); end
                checks++; if (c !== 64'd25) begin errors++; $display("FAIL fair_prod_%0d: got %0d want 25", k, c); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int id; logic [63:0] c; logic [3:0] vec; bit ok; exp_t e; int acks1; bit quiet;
        acks1 = ack_cnt[1];
        drive_req(1, 32'd1000, 32'd1000);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ack_cnt[1] != acks1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL mid_ack_timeout: no req_ack[1]"); end
        repeat (3) @(negedge clk);
        checks++; if (dut.state_q !== 3'd2) begin errors++; $display("FAIL mid_in_wait: got %0d want 2", dut.state_q); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_ack !== 4'b0 || rsp_valid !== 4'b0) begin errors++; $display("FAIL mid_reset_hs: ack=%b valid=%b want 0", req_ack, rsp_valid); end
        checks++; if (rsp_c !== 64'h0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_out: rsp_c=%h busy=%b want 0", rsp_c, busy); end
        rst = 1'b0;
        sb.delete();
        quiet = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0 || req_ack !== 4'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL mid_discard: stale activity after reset"); end
        drive_req(3, 32'd100, 32'd200);
        serve_one(0, id, c, vec, ok);
        checks++;
        if (!ok || sb.size() == 0) begin errors++; $display("FAIL mid_next_timeout: ok=%0d", ok); end
        else begin
            e = sb.pop_front();
            checks++; if (id != 3) begin errors++; $display("FAIL mid_next_id: got %0d want 3", id); end
            checks++; if (c !== 64'd20000 || c !== e.prod) begin errors++; $display("FAIL mid_next_prod: got %0d want 20000", c); end
        end
    endtask

    task automatic test_stale_done();
        int id; logic [63:0] c; logic [3:0] vec; bit ok; exp_t e;
        rst = 1'b1;
        sb.delete();
        force dut.mul_done = 1'b1;
        drive_req(2, 32'd9, -32'sd11);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (dut.mul_recieved_q !== 1'b1) begin errors++; $display("FAIL stale_recieved: got %b want 1", dut.mul_recieved_q); end
        checks++; if (busy !== 1'b0 || dut.mul_load_q !== 1'b0) begin errors++; $display("FAIL stale_no_grant: busy=%b load=%b want 0/0", busy, dut.mul_load_q); end
        checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL stale_no_ack: got %b want 0000", req_ack); end
        release dut.mul_done;
        serve_one(0, id, c, vec, ok);
        checks++;
        if (!ok || sb.size() == 0) begin errors++; $display("FAIL stale_timeout: ok=%0d", ok); end
        else begin
            e = sb.pop_front();
            checks++; if (id != 2 || c !== e.prod) begin errors++; $display("FAIL stale_result: got id %0d c %h want id 2 c %h", id, c, e.prod); end
        end
        checks++; if (dut.mul_recieved_q !== 1'b0) begin errors++; $display("FAIL stale_cleared: got %b want 0", dut.mul_recieved_q); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack_cnt[i] = 0;
            reload[i]  = 0;
        end
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_stale_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
